// File: rtl/j17_pkg.sv
// j17_pkg: shared opcodes, branch-control encodings and sequencer state encoding for the J17 core
package j17_pkg;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_CMP  = 6'd6;
    localparam logic [5:0] OP_MOV  = 6'd7;
    localparam logic [5:0] OP_MOVI = 6'd8;

    localparam logic [4:0] PC_SEQ = 5'd0;
    localparam logic [4:0] PC_JE  = 5'd1;
    localparam logic [4:0] PC_JB  = 5'd2;
    localparam logic [4:0] PC_JA  = 5'd3;
    localparam logic [4:0] PC_JNE = 5'd4;
    localparam logic [4:0] PC_JBE = 5'd5;
    localparam logic [4:0] PC_JAE = 5'd6;
    localparam logic [4:0] PC_JNZ = 5'd7;
    localparam logic [4:0] PC_JZ  = 5'd8;
    localparam logic [4:0] PC_JMP = 5'd9;
    localparam logic [4:0] PC_HLT = 5'd10;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_ALU = 3'd3,
        ST_WB       = 3'd4,
        ST_NEXT     = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h6400_0000;
endpackage

// File: rtl/cpu_sequencer_branch_cond.sv
// branch_cond: resolves whether a pc_control code branches, given the registered ALU flags
module branch_cond
    import j17_pkg::*;
(
    input  logic [4:0] pc_control,
    input  logic       eq,
    input  logic       below,
    input  logic       above,
    input  logic       zero,
    output logic       take
);
    always_comb begin
        take = 1'b0;
        case (pc_control)
            PC_JE:   take = eq;
            PC_JB:   take = below;
            PC_JA:   take = above;
            PC_JNE:  take = !eq;
            PC_JBE:  take = below | eq;
            PC_JAE:  take = above | eq;
            PC_JNZ:  take = !zero;
            PC_JZ:   take = zero;
            PC_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute sequencer for the J17 core
// Owns PC and IR, fetches over a req/ack port and steps ALU, register write and branch resolution.
module cpu_sequencer
    import j17_pkg::*;
#(
    parameter int PC_W     = 21,
    parameter int RESET_PC = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic [5:0]      alucode,
    input  logic            writecode,
    input  logic [4:0]      pc_control,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic            alu_eq,
    input  logic            alu_below,
    input  logic            alu_above,
    input  logic            alu_zero,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [2:0]      state
);
    state_t st, st_nx;
    logic   f_eq, f_below, f_above, f_zero, take;

    branch_cond u_branch (
        .pc_control(pc_control),
        .eq        (f_eq),
        .below     (f_below),
        .above     (f_above),
        .zero      (f_zero),
        .take      (take)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) st <= ST_FETCH;
        else          st <= st_nx;
    end

    // flags persist until the next completed ALU op, so branches see the latest compare
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc                               <= PC_W'(RESET_PC);
            ir                               <= NOP_WORD;
            {f_eq, f_below, f_above, f_zero} <= 4'b0;
        end else begin
            if (st == ST_FETCH && imem_ack) ir <= imem_rdata;
            if (st == ST_WAIT_ALU && alu_done) {f_eq, f_below, f_above, f_zero} <= {alu_eq, alu_below, alu_above, alu_zero};
            if (st == ST_NEXT) pc <= take ? ir[PC_W-1:0] : pc + PC_W'(1);
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            ST_FETCH:    st_nx = imem_ack ? ST_DECODE : ST_FETCH;
            ST_DECODE:   st_nx = pc_control == PC_HLT ? ST_HALT :
                                 alucode != 6'd0      ? ST_EXEC :
                                 writecode            ? ST_WB   : ST_NEXT;
            ST_EXEC:     st_nx = ST_WAIT_ALU;
            ST_WAIT_ALU: st_nx = alu_done ? ST_WB : ST_WAIT_ALU;
            ST_WB:       st_nx = ST_NEXT;
            ST_NEXT:     st_nx = ST_FETCH;
            default:     st_nx = ST_HALT;
        endcase
    end

    // the reset state is FETCH, so the request is also gated by reset_n to stay low while held
    always_comb begin
        imem_req  = reset_n && st == ST_FETCH;
        imem_addr = pc;
        alu_start = st == ST_EXEC;
        reg_we    = st == ST_WB;
        halted    = st == ST_HALT;
        state     = st;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: bench acting as memory, decoder and ALU, with an instruction-level timing model
module tb_cpu_sequencer;
    import j17_pkg::*;
    localparam int PC_W   = 21;
    localparam int RST_PC = 0;

    logic            clock = 0, reset_n = 0;
    logic            imem_req, imem_ack = 0;
    logic [PC_W-1:0] imem_addr, pc;
    logic [31:0]     imem_rdata = NOP_WORD, ir;
    logic [5:0]      alucode = 0;
    logic            writecode = 0;
    logic [4:0]      pc_control = 0;
    logic            alu_start, alu_done = 0, alu_eq = 0, alu_below = 0, alu_above = 0, alu_zero = 0;
    logic            reg_we, halted;
    logic [2:0]      state;

    cpu_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .alucode(alucode),
        .writecode(writecode), .pc_control(pc_control), .alu_start(alu_start),
        .alu_done(alu_done), .alu_eq(alu_eq), .alu_below(alu_below), .alu_above(alu_above),
        .alu_zero(alu_zero), .reg_we(reg_we), .pc(pc), .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    logic [31:0] mem [int];
    int ack_delay = 0;
    bit spur = 0;
    int n_start = 0, n_we = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [PC_W-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : NOP_WORD;
    endfunction

    // flags nibble is {eq, below, above, zero}
    function automatic bit br_taken(input int pcc, input logic [3:0] f);
        case (pcc)
            1: return f[3];
            2: return f[2];
            3: return f[1];
            4: return !f[3];
            5: return f[2] || f[3];
            6: return f[1] || f[3];
            7: return !f[0];
            8: return f[0];
            9: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU words carry the done delay in [7:4] and the resulting flags in [3:0]
    function automatic logic [31:0] mk_alu(input logic [5:0] op, input int d, input logic [3:0] f);
        return {op, 18'd0, 4'(d), f};
    endfunction

    function automatic logic [31:0] mk_br(input logic [4:0] pcc, input int tgt);
        return {6'(32 + int'(pcc)), 5'd0, 21'(tgt)};
    endfunction

    // per-cycle driver and compare process: checks outputs, then drives memory/decoder/ALU
    initial begin
        int cyc = 0, fs = 0, start_c = -1, we_c = -1, halt_c = 1 << 30, wcnt = 0, acnt = 0, gap;
        logic [PC_W-1:0] exp_pc = PC_W'(RST_PC), pend_pc = PC_W'(RST_PC);
        logic [31:0] exp_ir = NOP_WORD, w;
        logic [3:0] mflags = 0;
        logic [5:0] op;
        int pcc;
        bit e_halt, e_req;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                exp_pc = PC_W'(RST_PC); pend_pc = PC_W'(RST_PC); exp_ir = NOP_WORD; mflags = 0;
                fs = cyc; start_c = -1; we_c = -1; halt_c = 1 << 30; acnt = 0;
            end
            if (cyc == fs) exp_pc = pend_pc;
            e_halt = cyc >= halt_c;
            e_req  = reset_n && !e_halt && cyc >= fs;
            check("imem_req", 32'(imem_req), 32'(e_req));
            check("imem_addr", 32'(imem_addr), 32'(exp_pc));
            check("pc", 32'(pc), 32'(exp_pc));
            check("ir", ir, exp_ir);
            check("alu_start", 32'(alu_start), 32'(cyc == start_c));
            check("reg_we", 32'(reg_we), 32'(cyc == we_c));
            check("halted", 32'(halted), 32'(e_halt));
            n_start += int'(alu_start);
            n_we    += int'(reg_we);
            imem_rdata = rd(imem_addr);
            imem_ack   = imem_req && wcnt >= ack_delay;
            wcnt       = imem_req ? wcnt + 1 : 0;
            op         = ir[31:26];
            alucode    = (op >= 6'd1 && op <= 6'd6) ? op : 6'd0;
            writecode  = op == OP_MOV || op == OP_MOVI;
            pc_control = op >= 6'd32 ? 5'(op - 6'd32) : PC_SEQ;
            {alu_eq, alu_below, alu_above, alu_zero} = 4'($urandom);
            alu_done = 0;
            if (alu_start) acnt = int'(ir[7:4]);
            else if (acnt > 0) begin
                acnt--;
                if (acnt == 0) begin
                    alu_done = 1;
                    {alu_eq, alu_below, alu_above, alu_zero} = ir[3:0];
                end
            end else alu_done = spur && $urandom_range(0, 1) == 1;
            if (reset_n && imem_req && imem_ack) begin
                w      = rd(exp_pc);
                op     = w[31:26];
                pcc    = op >= 6'd32 ? int'(op) - 32 : 0;
                exp_ir = w;
                if (pcc == 10) begin
                    halt_c = cyc + 2;
                    fs     = 1 << 30;
                end else begin
                    if (op >= 6'd1 && op <= 6'd6) begin
                        mflags  = w[3:0];
                        gap     = 5 + int'(w[7:4]);
                        start_c = cyc + 2;
                        we_c    = cyc + gap - 2;
                    end else if (op == OP_MOV || op == OP_MOVI) begin
                        gap  = 4;
                        we_c = cyc + 2;
                    end else gap = 3;
                    pend_pc = br_taken(pcc, mflags) ? w[PC_W-1:0] : exp_pc + PC_W'(1);
                    fs      = cyc + gap;
                end
            end
        end
    end

    task automatic hold();
        @(posedge clock); #2 reset_n = 0;
        mem.delete();
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clock);
        #2 reset_n = 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // plain NOP stream from reset
        hold(); release_rst();
        cycles(3); check("nop_pc1", 32'(pc), 32'd1);
        cycles(3); check("nop_pc2", 32'(pc), 32'd2);

        // ADD with done two cycles after start, then JE taken on eq=1
        hold();
        mem[0] = mk_alu(OP_ADD, 2, 4'b1000);
        mem[1] = mk_br(PC_JE, 'h40);
        n_start = 0; n_we = 0;
        release_rst();
        cycles(7); check("add_pc", 32'(pc), 32'd1);
        check("add_starts", 32'(n_start), 32'd1);
        check("add_wes", 32'(n_we), 32'd1);
        cycles(3); check("je_taken_pc", 32'(pc), 32'h40);

        // JE not taken on eq=0, stray alu_done outside WAIT_ALU
        hold();
        mem[0] = mk_alu(OP_CMP, 1, 4'b0000);
        mem[1] = mk_br(PC_JE, 'h40);
        spur = 1;
        release_rst();
        cycles(9); check("je_not_taken_pc", 32'(pc), 32'd2);

        // branch mix with flag persistence, slow acks
        hold();
        mem['h000] = mk_alu(OP_ADD, 1, 4'b0100);
        mem['h001] = mk_br(PC_JB, 'h10);
        mem['h010] = mk_br(PC_JA, 'h30);
        mem['h011] = mk_br(PC_JBE, 'h20);
        mem['h020] = {OP_MOV, 26'd0};
        mem['h021] = mk_br(PC_JAE, 'h30);
        mem['h022] = mk_alu(OP_SUB, 3, 4'b1001);
        mem['h023] = mk_br(PC_JNZ, 'h30);
        mem['h024] = mk_br(PC_JZ, 'h28);
        mem['h028] = mk_br(PC_JNE, 'h30);
        mem['h029] = mk_br(PC_JAE, 'h2C);
        mem['h02C] = mk_br(5'd15, 'h30);
        mem['h02D] = mk_br(PC_JMP, 'h100);
        mem['h100] = mk_br(PC_HLT, 0);
        ack_delay = 2;
        release_rst();
        cycles(200);
        check("prog_halted", 32'(halted), 32'd1);
        check("prog_pc", 32'(pc), 32'h100);
        check("prog_state", 32'(state), 32'(ST_HALT));

        // JMP near the top of the PC space and wrap to 0
        hold();
        mem[0] = mk_br(PC_JMP, 'h1FFFF0);
        ack_delay = 0; spur = 0;
        release_rst();
        cycles(3);  check("jmp_top_pc", 32'(pc), 32'h1FFFF0);
        cycles(45); check("top_pc", 32'(pc), 32'h1FFFFF);
        cycles(3);  check("wrap_pc", 32'(pc), 32'd0);

        // HLT
        hold();
        mem[0] = mk_br(PC_HLT, 0);
        release_rst();
        cycles(2);  check("hlt_halted", 32'(halted), 32'd1);
        cycles(20); check("hlt_req", 32'(imem_req), 32'd0);
        check("hlt_pc", 32'(pc), 32'd0);

        // reset while a slow fetch is pending
        hold();
        mem[0]    = mk_br(PC_JMP, 'h55);
        mem['h55] = {OP_MOV, 26'd0};
        release_rst();
        cycles(3); check("rst_jmp_pc", 32'(pc), 32'h55);
        check("rst_jmp_ir", ir, mk_br(PC_JMP, 'h55));
        ack_delay = 5;
        cycles(2); check("rst_wait_req", 32'(imem_req), 32'd1);
        @(posedge clock); #2 reset_n = 0;
        #1;
        check("rst_req_drop", 32'(imem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'(RST_PC));
        check("rst_ir", ir, NOP_WORD);
        release_rst();
        cycles(7); check("rst_refetch_pc0", 32'(pc), 32'(RST_PC));
        cycles(1); check("rst_refetch_pc", 32'(pc), 32'h55);

        cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
